// File: rtl/servo_pkg.sv
// Shared servo constants and the duty clamp helper used by servo pulse blocks.
package servo_pkg;

  localparam logic [7:0] SERVO_DUTY_MIN    = 8'h06;
  localparam logic [7:0] SERVO_DUTY_MAX    = 8'h1a;
  localparam int         SERVO_FRAME_TICKS = 256;

  function automatic logic [7:0] servo_clamp(input logic [7:0] duty,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
    if (duty < lo)      return lo;
    else if (duty > hi) return hi;
    else                return duty;
  endfunction

endpackage

// File: rtl/servo_tick_prescaler.sv
// Free-running tick prescaler: one tick every divClk+1 clocks.
module servo_tick_prescaler (
  input  logic        clk,
  input  logic        resetb,
  input  logic [15:0] divClk,
  output logic        tick
);

  logic [15:0] pcnt_q;

  // >= so that lowering divClk mid-count ticks at once instead of wrapping
  assign tick = (pcnt_q >= divClk);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)   pcnt_q <= '0;
    else if (tick) pcnt_q <= '0;
    else           pcnt_q <= pcnt_q + 16'd1;
  end

endmodule

// File: rtl/servo_pwm_gen.sv
// Framed servo PWM: clamps the duty command, applies an optional per-frame
// slew limit and enable gating at frame boundaries, drives a registered pulse.
module servo_pwm_gen
  import servo_pkg::*;
#(
  parameter int         FRAME_TICKS = SERVO_FRAME_TICKS,
  parameter logic [7:0] DUTY_MIN    = SERVO_DUTY_MIN,
  parameter logic [7:0] DUTY_MAX    = SERVO_DUTY_MAX,
  parameter int         MAX_STEP    = 0
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  setPwm,
  input  logic [15:0] divClk,
  input  logic        enable,
  output logic        pwm,
  output logic        frame_start,
  output logic [7:0]  duty_cur,
  output logic        busy
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAME_TICKS - 1);
  // A step wider than any possible distance behaves like 255
  localparam int         STEP_SAT   = (MAX_STEP > 255) ? 255 : MAX_STEP;
  localparam logic [8:0] STEP9      = 9'(STEP_SAT);
  localparam logic [7:0] STEP8      = 8'(STEP_SAT);

  logic       tick;
  logic       boundary;
  logic [7:0] tgt;
  logic [7:0] fcnt_q;
  logic [7:0] duty_q, duty_d;
  logic       primed_q, en_q, pwm_q, fs_q;
  logic       up;
  logic [8:0] diff9;

  servo_tick_prescaler u_presc (
    .clk    (clk),
    .resetb (resetb),
    .divClk (divClk),
    .tick   (tick)
  );

  assign tgt      = servo_clamp(setPwm, DUTY_MIN, DUTY_MAX);
  assign boundary = tick && (fcnt_q == FRAME_LAST);

  always_comb begin
    up     = (tgt > duty_q);
    diff9  = up ? ({1'b0, tgt} - {1'b0, duty_q}) : ({1'b0, duty_q} - {1'b0, tgt});
    duty_d = tgt;
    // Partial step lands strictly between duty_q and tgt, so 8 bits cannot wrap
    if (primed_q && (MAX_STEP != 0) && (diff9 > STEP9))
      duty_d = up ? (duty_q + STEP8) : (duty_q - STEP8);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      fcnt_q   <= '0;
      duty_q   <= '0;
      primed_q <= 1'b0;
      en_q     <= 1'b0;
      pwm_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      fs_q  <= boundary;
      pwm_q <= en_q && primed_q && (fcnt_q < duty_q);
      if (tick)
        fcnt_q <= boundary ? 8'd0 : (fcnt_q + 8'd1);
      if (boundary) begin
        duty_q   <= duty_d;
        primed_q <= 1'b1;
        en_q     <= enable;
      end
    end
  end

  assign pwm         = pwm_q;
  assign frame_start = fs_q;
  assign duty_cur    = duty_q;
  assign busy        = primed_q && (duty_q != tgt);

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: two instances (no slew / MAX_STEP=2) against a
// pulse-width level model, plus directed literal expectations.
module tb_servo_pwm_gen;

  localparam int FT = 256;

  logic        clk = 1'b0;
  logic        resetb;
  logic        enable;
  logic [7:0]  setPwm;
  logic [15:0] divClk;

  logic        pwm_w  [2];
  logic        fs_w   [2];
  logic        busy_w [2];
  logic [7:0]  duty_w [2];

  always #5 clk = ~clk;

  servo_pwm_gen #(.MAX_STEP(0)) dut0 (
    .clk(clk), .resetb(resetb), .setPwm(setPwm), .divClk(divClk), .enable(enable),
    .pwm(pwm_w[0]), .frame_start(fs_w[0]), .duty_cur(duty_w[0]), .busy(busy_w[0]));

  servo_pwm_gen #(.MAX_STEP(2)) dut1 (
    .clk(clk), .resetb(resetb), .setPwm(setPwm), .divClk(divClk), .enable(enable),
    .pwm(pwm_w[1]), .frame_start(fs_w[1]), .duty_cur(duty_w[1]), .busy(busy_w[1]));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // ---------------- model: frames as clock spans, pulses as clock counts ----
  function automatic int mclamp(input int v);
    if (v < 6)  return 6;
    if (v > 26) return 26;
    return v;
  endfunction

  function automatic int mslew(input bit primed, input int cur, input int tgt, input int step);
    if (!primed || step == 0) return tgt;
    if (tgt > cur) return (tgt - cur <= step) ? tgt : cur + step;
    return (cur - tgt <= step) ? tgt : cur - step;
  endfunction

  int   m_clk;
  bit   m_fs;
  bit   m_primed [2];
  bit   m_pwm    [2];
  int   m_duty   [2];
  int   m_left   [2];
  logic m_bnd;

  assign m_bnd = (m_clk == (int'(divClk) + 1) * FT - 1);

  always @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      m_clk <= 0;
      m_fs  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_primed[i] <= 1'b0;
        m_pwm[i]    <= 1'b0;
        m_duty[i]   <= 0;
        m_left[i]   <= 0;
      end
    end else begin
      m_clk <= m_bnd ? 0 : m_clk + 1;
      m_fs  <= m_bnd;
      for (int i = 0; i < 2; i++) begin
        m_pwm[i] <= (m_left[i] > 0);
        if (m_bnd) begin
          m_duty[i]   <= mslew(m_primed[i], m_duty[i], mclamp(int'(setPwm)), 2 * i);
          m_left[i]   <= enable ? mslew(m_primed[i], m_duty[i], mclamp(int'(setPwm)), 2 * i)
                                  * (int'(divClk) + 1) : 0;
          m_primed[i] <= 1'b1;
        end else if (m_left[i] > 0) begin
          m_left[i] <= m_left[i] - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && resetb) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("pwm%0d", i),   int'(pwm_w[i]),  int'(m_pwm[i]));
        chk($sformatf("fs%0d", i),    int'(fs_w[i]),   int'(m_fs));
        chk($sformatf("duty%0d", i),  int'(duty_w[i]), m_duty[i]);
        chk($sformatf("busy%0d", i),  int'(busy_w[i]),
            int'(m_primed[i] && (m_duty[i] != mclamp(int'(setPwm)))));
      end
    end
  end

  // high-clock count of dut0's pulse in the frame that just ended
  int cnt_w = 0;
  int last_w = 0;
  always @(negedge clk) begin
    if (fs_w[0]) begin
      last_w <= cnt_w;
      cnt_w  <= 0;
    end else begin
      cnt_w <= cnt_w + (pwm_w[0] ? 1 : 0);
    end
  end

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fs_w[0] && n < 3000);
    if (!fs_w[0]) begin
      errors++;
      $display("FAIL wait_fs timeout actual=%0d clocks required=frame_start", n);
    end
    #1;
  endtask

  int n;
  int exp_s [5] = '{8, 10, 12, 14, 15};
  int exp_b [5] = '{1, 1, 1, 1, 0};

  initial begin
    resetb = 1'b0;
    divClk = 16'd3;
    setPwm = 8'h0f;
    enable = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pwm",  int'(pwm_w[0]),  0);
    chk("rst_fs",   int'(fs_w[0]),   0);
    chk("rst_duty", int'(duty_w[0]), 0);
    chk("rst_busy", int'(busy_w[0]), 0);
    #1 resetb = 1'b1;

    // basic pulse and clamp
    wait_fs(n);
    chk("first_fs_clocks", n, 1024);
    chk("basic_duty0", int'(duty_w[0]), 15);
    chk("basic_duty1", int'(duty_w[1]), 15);
    setPwm = 8'hff;
    wait_fs(n);
    chk("frame_period", n, 1024);
    chk("basic_width", last_w, 60);
    chk("clamp_hi_duty", int'(duty_w[0]), 26);
    chk("slew_up_first", int'(duty_w[1]), 17);
    setPwm = 8'h00;
    wait_fs(n);
    chk("clamp_hi_width", last_w, 104);
    chk("clamp_lo_duty", int'(duty_w[0]), 6);
    wait_fs(n);
    chk("clamp_lo_width", last_w, 24);

    // let the slewed instance settle at 6 (13, 11, 9, 7, 6)
    repeat (4) wait_fs(n);
    chk("settle_duty1", int'(duty_w[1]), 6);
    chk("settle_busy1", int'(busy_w[1]), 0);
    setPwm = 8'h0f;
    for (int k = 0; k < 5; k++) begin
      wait_fs(n);
      chk($sformatf("slew_duty_%0d", k), int'(duty_w[1]), exp_s[k]);
      chk($sformatf("slew_busy_%0d", k), int'(busy_w[1]), exp_b[k]);
    end

    // mid-frame changes of setPwm and enable
    setPwm = 8'h0a;
    wait_fs(n);
    chk("mid_duty0", int'(duty_w[0]), 10);
    repeat (20) @(negedge clk);
    chk("mid_pwm_high", int'(pwm_w[0]), 1);
    #1;
    setPwm = 8'h14;
    enable = 1'b0;
    wait_fs(n);
    chk("mid_width", last_w, 40);
    chk("mid_duty_next", int'(duty_w[0]), 20);
    repeat (100) @(negedge clk);
    #1 enable = 1'b1;
    wait_fs(n);
    chk("disabled_width", last_w, 0);
    wait_fs(n);
    chk("reenable_width", last_w, 80);

    // reset during a pulse
    repeat (10) @(negedge clk);
    chk("pre_rst_pwm", int'(pwm_w[0]), 1);
    #1 resetb = 1'b0;
    #1;
    chk("rst_mid_pwm0", int'(pwm_w[0]), 0);
    chk("rst_mid_pwm1", int'(pwm_w[1]), 0);
    chk("rst_mid_duty1", int'(duty_w[1]), 0);
    setPwm = 8'h0f;
    repeat (3) @(negedge clk);
    #1 resetb = 1'b1;
    wait_fs(n);
    chk("rst_first_fs", n, 1024);
    chk("rst_noslew_duty1", int'(duty_w[1]), 15);
    chk("rst_noslew_busy1", int'(busy_w[1]), 0);

    // lowering divClk mid-count must tick at once, not wrap
    @(negedge clk);
    #1 resetb = 1'b0;
    divClk = 16'd2200;
    repeat (2) @(negedge clk);
    #1 resetb = 1'b1;
    repeat (1500) @(negedge clk);
    #1;
    chk_en = 1'b0;
    divClk = 16'd3;
    n = 0;
    while (!fs_w[0] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("div_drop_clocks", n, 1021);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_gen.md
# servo_pwm_gen

Per-channel servo pulse generator that turns an 8-bit duty command (`setPwm`, in prescaler ticks) into a framed PWM output for an SG90-class servo. It sits directly downstream of the servo sweep/command controller. It consumes that controller's `setPwm` and `divClk` and drives the servo pin. Each frame it applies the command with range clamping, an optional per-frame slew limit and enable gating, and it reports frame boundaries back upstream.

## Interface
- `FRAME_TICKS`, 256: ticks per PWM frame (2..256). At 24 MHz with `divClk`=2200 this gives ≈23.5 ms.
- `DUTY_MIN`, 8'h06: lowest applied duty, in ticks.
- `DUTY_MAX`, 8'h1a: highest applied duty, in ticks.
- `MAX_STEP`, 0: maximum duty change per frame, in ticks. 0 means no slew limit.
- `clk`  in  1  system clock.
- `resetb`  in  1  reset, asynchronous and active-low.
- `setPwm`  in  8  commanded duty in ticks. Level signal, sampled only at frame boundaries.
- `divClk`  in  16  prescaler terminal count. Tick period is `divClk`+1 clocks.
- `enable`  in  1  output enable. Sampled only at frame boundaries.
- `pwm`  out  1  servo pulse, registered.
- `frame_start`  out  1  one-clock strobe on the clock where a new frame begins.
- `duty_cur`  out  8  duty applied in the current frame.
- `busy`  out  1  high while `duty_cur` is not equal to the clamped target (slew in progress).

## Operation
- **Prescaler.**
  - `pcnt` (16 bit) increments every clock.
  - When `pcnt >= divClk`: `tick`=1 and `pcnt`←0.
  - The `>=` compare makes a reduction of `divClk` mid-count take effect without a 65536-count wrap.
  - `divClk`=0 gives a tick every clock.
- **Frame counter.**
  - `fcnt` (8 bit) advances on `tick`.
  - On `tick` with `fcnt`==`FRAME_TICKS`-1, `fcnt` wraps to 0. This is a frame boundary.
- **Frame boundary actions.** All happen on the same clock, and `frame_start`=1 on that clock.
  - Compute the target: `tgt` = clamp(`setPwm`, `DUTY_MIN`, `DUTY_MAX`).
  - If `primed`=0: `duty_cur`←`tgt` and `primed`←1. The first frame after reset has no slew.
  - Else if `MAX_STEP`=0: `duty_cur`←`tgt`.
  - Else: `duty_cur` moves toward `tgt` by min(|`tgt`−`duty_cur`|, `MAX_STEP`). Never overshoot.
  - Arithmetic uses 9-bit unsigned intermediates. There is no wrap at 0 or 255.
  - `en_q`←`enable`.
- **Output.**
  - `pwm` ← `en_q` & `primed` & (`fcnt` < `duty_cur`).
  - Pulses are always whole. Changes to `enable` and `setPwm` never produce runt or stretched pulses mid-frame.
- **Busy.** `busy` = `primed` & (`duty_cur` != clamp(`setPwm`)). It is combinational on the live `setPwm`.

## Timing
- **Reset values:** `pcnt`=0, `fcnt`=0, `duty_cur`=0, `primed`=0, `en_q`=0, `pwm`=0, `frame_start`=0, `busy`=0.
- After reset release, the first `frame_start` occurs once `FRAME_TICKS` ticks have elapsed: (`divClk`+1)·`FRAME_TICKS` clocks. `pwm` stays 0 until then.
- `pwm` lags the `fcnt`/`duty_cur` state by 1 clock (registered).
- The rising edge of `pwm` comes 1 clock after `frame_start`.
- The pulse width is exactly `duty_cur`·(`divClk`+1) clocks, provided `divClk` is constant during the frame.
- Changing `setPwm` mid-frame has no effect until the next boundary. If it toggles and returns before the boundary, nothing is applied.
- Reset asserted mid-pulse forces `pwm`=0 asynchronously. The next frame after release is handled as the first frame (`primed`=0).
- When the boundary and an `enable` change coincide, the sampled value applies to the whole new frame.

## Structure
- Shared package `servo_pkg` holds:
  - the default constants `SERVO_DUTY_MIN`=8'h06, `SERVO_DUTY_MAX`=8'h1a and `SERVO_FRAME_TICKS`=256;
  - the function `servo_clamp(duty, lo, hi)`.
- One sub-module, `servo_tick_prescaler`, with ports (`clk`, `resetb`, `divClk`, `tick`). It is reused by other tick-based blocks.
- Frame counter, slew logic and output register stay in `servo_pwm_gen`.

## Test plan
- **Basic pulse.** `divClk`=3, `setPwm`=8'h0f, `enable`=1, release reset. Required:
  - first `frame_start` after 1024 clocks;
  - `duty_cur`=15;
  - `pwm` high for exactly 60 clocks, once per 1024-clock frame.
- **Clamp.** `setPwm`=8'h00 gives `duty_cur`=6 (24 clocks high). `setPwm`=8'hff gives `duty_cur`=26 (104 clocks high).
- **Slew.** `MAX_STEP`=2, settled at 6, `setPwm`=8'h0f. Required:
  - `duty_cur` sequence 8, 10, 12, 14, 15 on successive frames;
  - `busy` deasserts at the boundary where 15 is applied.
- **Mid-frame changes.** `setPwm` 8'h0a→8'h14 and `enable` 1→0, both mid-pulse. Required:
  - current pulse completes at 10 ticks;
  - next frame `pwm` stays 0;
  - re-enable: pulse of 20 ticks at the following frame.
- **`divClk` change and reset.**
  - Lower `divClk` from 2200 to 3 while `pcnt`=1500: a tick occurs on the next clock, with no 65536-clock stall.
  - Assert `resetb` during a pulse: `pwm`=0 immediately.
  - After release, the first frame loads `setPwm` directly, with no slew.
